// File: rtl/arith_result_accumulator.sv
// -----------------------------------------------------------------------------
// arith_result_accumulator
//
// Purpose:
//   Sits downstream of the 3-bit adder/multiplier datapath. It accepts a stream
//   of unsigned DATA_W-bit results over a valid/ready handshake and sums a
//   programmed number of them (1 .. 2^CNT_W-1, or 0 for an empty run). The
//   output stage provides the registered total, a one-cycle done pulse and a
//   sticky overflow flag.
//
// Ports:
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   start     in   1       run request, sampled only in IDLE
//   count     in   CNT_W   number of results in the run, sampled with start
//   in_valid  in   1       in_data valid
//   in_ready  out  1       a transfer can occur this cycle (RUN only)
//   in_data   in   DATA_W  unsigned result to accumulate
//   acc_out   out  ACC_W   registered accumulator
//   busy      out  1       high in RUN and DONE
//   done      out  1       one-cycle pulse, acc_out holds the final total
//   ovf       out  1       sticky overflow for the current run
//
// Build options:
//   ACC_SATURATE_EN  when defined, an overflowing run clamps acc_out to all
//                    ones for the rest of the run; otherwise acc_out wraps
//                    modulo 2^ACC_W. ovf is set in both builds.
// -----------------------------------------------------------------------------
module arith_result_accumulator #(
    parameter int DATA_W = 6,
    parameter int ACC_W  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int PAD_W = ACC_W + 1 - DATA_W;

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_rem;
    logic             r_ovf;

    logic             w_xfer;
    logic [ACC_W:0]   w_sum;

    // in_ready, busy and done are plain state decodes, no register stage.
    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN) || (r_state == S_DONE);
    assign done     = (r_state == S_DONE);

    assign w_xfer   = in_valid && in_ready;

    // One bit wider than the accumulator: the top bit is the carry-out.
    assign w_sum    = {1'b0, r_acc} + {{PAD_W{1'b0}}, in_data};

    assign acc_out  = r_acc;
    assign ovf      = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_rem   <= count;
                        r_state <= (count == '0) ? S_DONE : S_RUN;
                    end
                end

                S_RUN: begin
                    if (w_xfer) begin
`ifdef ACC_SATURATE_EN
                        // Once the run has overflowed, hold the clamp even if
                        // later additions would not carry on their own.
                        if (w_sum[ACC_W] || r_ovf) begin
                            r_acc <= '1;
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
`else
                        r_acc <= w_sum[ACC_W-1:0];
`endif
                        if (w_sum[ACC_W]) begin
                            r_ovf <= 1'b1;
                        end
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_result_accumulator.sv
module tb_arith_result_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] count;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic [7:0] acc_out;
    logic       busy;
    logic       done;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] acc;
        logic       ovf;
    } exp_t;

    exp_t part_q[$];
    exp_t fin_q[$];

    always #5 clk = ~clk;

    arith_result_accumulator #(
        .DATA_W(6),
        .ACC_W (8),
        .CNT_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .count   (count),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .acc_out (acc_out),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    // Reference: the value shown after summing 'total' worth of results.
    function automatic exp_t model(input int total);
        exp_t e;
        e.ovf = (total > 255);
`ifdef ACC_SATURATE_EN
        e.acc = (total > 255) ? 8'hFF : total[7:0];
`else
        e.acc = total[7:0];
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: transfers seen at a rising edge are checked at the next falling
    // edge against the running-sum queue; every done pulse pops a final result.
    initial begin
        logic xfer;
        exp_t e;
        forever begin
            @(posedge clk);
            xfer = in_valid && in_ready && rst_n;
            @(negedge clk);
            if (rst_n) begin
                if (xfer) begin
                    if (part_q.size() == 0) begin
                        check("unexpected_xfer", 1, 0);
                    end else begin
                        e = part_q.pop_front();
                        check("part_acc", acc_out, e.acc);
                        check("part_ovf", ovf, e.ovf);
                    end
                end
                if (done) begin
                    if (fin_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = fin_q.pop_front();
                        check("final_acc", acc_out, e.acc);
                        check("final_ovf", ovf, e.ovf);
                        check("done_busy", busy, 1);
                        check("done_ready", in_ready, 0);
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_acc"},   acc_out, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_ovf"},   ovf, 0);
        check({tag, "_ready"}, in_ready, 0);
    endtask

    // gap: 0 = back-to-back, >0 = exactly that many idle cycles between items,
    // -1 = random 0..3 idle cycles. fixed: data values to use (random if empty).
    task automatic run(input int cnt, input int gap, input bit poke,
                       input int abort_after, input int fixed[$]);
        int total = 0;
        int k = 0;
        int cycles = 0;
        int idle;
        int d;
        @(negedge clk);
        start = 1'b1;
        count = cnt[3:0];
        if (cnt == 0) fin_q.push_back(model(0));
        @(negedge clk);
        start = 1'b0;
        if (cnt == 0) begin
            check("zero_ready0", in_ready, 0);
            check("zero_busy0", busy, 1);
            @(negedge clk);
            check("zero_ready1", in_ready, 0);
            check("zero_busy1", busy, 0);
            check("zero_acc_hold", acc_out, 0);
            return;
        end
        while (k < cnt && cycles < 200) begin
            idle = 0;
            if (k > 0 && gap > 0) idle = gap;
            if (gap < 0) idle = $urandom_range(0, 3);
            for (int i = 0; i < idle; i++) begin
                in_valid = 1'b0;
                in_data  = 6'($urandom);
                start    = poke && (i == 0);
                count    = 4'($urandom);
                @(negedge clk);
                start = 1'b0;
                cycles++;
            end
            d = (fixed.size() > k) ? fixed[k] : int'($urandom_range(0, 63));
            in_valid = 1'b1;
            in_data  = d[5:0];
            if (poke && k == 1) start = 1'b1;
            if (in_ready) begin
                total += d;
                k++;
                part_q.push_back(model(total));
                if (k == cnt) fin_q.push_back(model(total));
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (abort_after > 0 && k == abort_after) begin
                in_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_all_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_all_zero("abort_idle");
                return;
            end
        end
        in_valid = 1'b0;
        check("run_timeout", (k == cnt), 1);
        // Now in the done cycle; a start here must be dropped.
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_hold", acc_out, model(total).acc);
    endtask

    initial begin
        int none[$];
        int q[$];
        rst_n    = 1'b1;
        start    = 1'b0;
        count    = '0;
        in_valid = 1'b0;
        in_data  = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("post_reset");

        q = '{5, 7, 9};
        run(3, 0, 1'b0, 0, q);
        run(0, 0, 1'b0, 0, none);
        q = '{63, 63, 63, 63, 63};
        run(5, 0, 1'b0, 0, q);
        run(2, 3, 1'b1, 0, none);
        run(4, 0, 1'b0, 2, none);
        q = '{10};
        run(1, 0, 1'b0, 0, q);
        q = '{63, 63, 63, 63, 63, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run(15, -1, 1'b0, 0, q);

        for (int r = 0; r < 25; r++) begin
            run(int'($urandom_range(0, 15)), -1, 1'($urandom), 0, none);
        end

        repeat (4) @(negedge clk);
        check("part_q_empty", part_q.size(), 0);
        check("fin_q_empty", fin_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
